// File: rtl/calc_seq_ctrl.sv
// calc_seq_ctrl: keypad-driven calculator sequencer.
// Builds signed decimal operands, parks operand A in the shared data memory,
// fetches it back on equals, computes add/sub/mul with overflow detection,
// writes the result to memory and drives the display.
module calc_seq_ctrl #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned ADDR_W = 16,
    parameter logic [ADDR_W-1:0] A_ADDR = ADDR_W'(0),
    parameter logic [ADDR_W-1:0] RES_ADDR = ADDR_W'(1),
    parameter int unsigned RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              key_valid,
    input  logic [3:0]        key_digit,
    input  logic              op_valid,
    input  logic [1:0]        op_code,
    input  logic              equal_input,
    input  logic              clear_input,
    output logic              complete,
    output logic              overflow,
    output logic              error,
    output logic [WIDTH-1:0]  display_output,
    output logic              oe,
    output logic              we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WIDTH-1:0]  mem_data_in,
    input  logic [WIDTH-1:0]  mem_data_out
);

    typedef enum logic [2:0] {
        ENTER_A, STORE_A, ENTER_B, FETCH_A, COMPUTE, WRITE_RES, DONE
    } state_t;

    localparam logic [WIDTH+3:0] ENTRY_MAX = {5'b0, {(WIDTH-1){1'b1}}};
    localparam logic [2:0]       LAT_LAST  = 3'(RD_LAT);

    state_t             state;
    logic [WIDTH-1:0]   entry;
    logic [WIDTH-1:0]   a_mem;
    logic [WIDTH-1:0]   b_reg;
    logic [WIDTH-1:0]   result_reg;
    logic [1:0]         op_reg;
    logic               b_digit;
    logic [2:0]         lat_cnt;

    logic               digit_ok;
    logic               digit_fits;
    logic [WIDTH+3:0]   digit_sum;
    logic signed [WIDTH:0]     a_sx, b_sx, sum_full;
    logic signed [2*WIDTH-1:0] a_sx2, b_sx2, prod_full;
    logic [WIDTH-1:0]   calc_low;
    logic               calc_ovf;

    // Candidate next entry value and whether it still fits the positive range
    always_comb begin
        digit_ok   = (key_digit <= 4'd9);
        digit_sum  = {4'b0, entry} * (WIDTH+4)'(10) + (WIDTH+4)'(key_digit);
        digit_fits = (digit_sum <= ENTRY_MAX);
    end

    // Full-precision arithmetic on fetched A and latched B, plus range check
    always_comb begin
        a_sx      = {a_mem[WIDTH-1], a_mem};
        b_sx      = {b_reg[WIDTH-1], b_reg};
        a_sx2     = {{WIDTH{a_mem[WIDTH-1]}}, a_mem};
        b_sx2     = {{WIDTH{b_reg[WIDTH-1]}}, b_reg};
        sum_full  = (op_reg == 2'd1) ? (a_sx - b_sx) : (a_sx + b_sx);
        prod_full = a_sx2 * b_sx2;
        calc_low  = '0;
        calc_ovf  = 1'b0;
        case (op_reg)
            2'd0, 2'd1: begin
                calc_low = sum_full[WIDTH-1:0];
                calc_ovf = sum_full[WIDTH] ^ sum_full[WIDTH-1];
            end
            2'd2: begin
                calc_low = prod_full[WIDTH-1:0];
                calc_ovf = !((prod_full[2*WIDTH-1:WIDTH-1] == '0) ||
                             (prod_full[2*WIDTH-1:WIDTH-1] == '1));
            end
            default: ;
        endcase
    end

    // Sequencer: event decode, operand entry, memory handshake, registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= ENTER_A;
            entry          <= '0;
            a_mem          <= '0;
            b_reg          <= '0;
            result_reg     <= '0;
            op_reg         <= '0;
            b_digit        <= 1'b0;
            lat_cnt        <= '0;
            complete       <= 1'b0;
            overflow       <= 1'b0;
            error          <= 1'b0;
            display_output <= '0;
            oe             <= 1'b0;
            we             <= 1'b0;
            mem_addr       <= '0;
            mem_data_in    <= '0;
        end else begin
            // Bus and strobe outputs are single-cycle unless re-asserted below;
            // this is also what aborts an access on clear.
            complete    <= 1'b0;
            oe          <= 1'b0;
            we          <= 1'b0;
            mem_addr    <= '0;
            mem_data_in <= '0;
            if (clear_input) begin
                state          <= ENTER_A;
                entry          <= '0;
                display_output <= '0;
                overflow       <= 1'b0;
                error          <= 1'b0;
                b_digit        <= 1'b0;
            end else begin
                case (state)
                    ENTER_A, ENTER_B, DONE: begin
                        if (equal_input) begin
                            if (state == ENTER_B) begin
                                b_reg    <= entry;
                                lat_cnt  <= '0;
                                oe       <= 1'b1;
                                mem_addr <= A_ADDR;
                                state    <= FETCH_A;
                            end
                        end else if (op_valid) begin
                            if (op_code == 2'd3) begin
                                error <= 1'b1;
                            end else if (state == ENTER_A) begin
                                op_reg      <= op_code;
                                we          <= 1'b1;
                                mem_addr    <= A_ADDR;
                                mem_data_in <= entry;
                                state       <= STORE_A;
                            end else if (state == DONE) begin
                                op_reg      <= op_code;
                                we          <= 1'b1;
                                mem_addr    <= A_ADDR;
                                mem_data_in <= result_reg;
                                state       <= STORE_A;
                            end else if (!b_digit) begin
                                op_reg <= op_code;
                            end
                        end else if (key_valid && digit_ok) begin
                            if (state == DONE) begin
                                entry          <= WIDTH'(key_digit);
                                display_output <= WIDTH'(key_digit);
                                overflow       <= 1'b0;
                                state          <= ENTER_A;
                            end else begin
                                if (state == ENTER_B) b_digit <= 1'b1;
                                if (digit_fits) begin
                                    entry          <= digit_sum[WIDTH-1:0];
                                    display_output <= digit_sum[WIDTH-1:0];
                                    overflow       <= 1'b0;
                                end
                            end
                        end
                    end
                    STORE_A: begin
                        entry   <= '0;
                        b_digit <= 1'b0;
                        state   <= ENTER_B;
                    end
                    FETCH_A: begin
                        if (lat_cnt == LAT_LAST) begin
                            a_mem <= mem_data_out;
                            state <= COMPUTE;
                        end else begin
                            lat_cnt <= lat_cnt + 3'd1;
                        end
                    end
                    COMPUTE: begin
                        result_reg     <= calc_low;
                        overflow       <= calc_ovf;
                        we             <= 1'b1;
                        mem_addr       <= RES_ADDR;
                        mem_data_in    <= calc_low;
                        display_output <= calc_low;
                        state          <= WRITE_RES;
                    end
                    WRITE_RES: begin
                        complete <= 1'b1;
                        state    <= DONE;
                    end
                    default: state <= ENTER_A;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_calc_seq_ctrl.sv
// tb_calc_seq_ctrl: scoreboard bench for calc_seq_ctrl. A transaction-level
// calculator model queues the expected memory traffic and completions; a
// monitor compares them whenever the DUT drives the bus or pulses complete.
module tb_calc_seq_ctrl;

    localparam int RD_LAT = 3;
    localparam logic [15:0] A_ADDR   = 16'h00A0;
    localparam logic [15:0] RES_ADDR = 16'h00B1;

    logic        clk = 1'b0;
    logic        reset;
    logic        key_valid, op_valid, equal_input, clear_input;
    logic [3:0]  key_digit;
    logic [1:0]  op_code;
    logic        complete, overflow, error, oe, we;
    logic [15:0] display_output, mem_addr, mem_data_in, mem_data_out;

    calc_seq_ctrl #(
        .WIDTH(16), .ADDR_W(16), .A_ADDR(A_ADDR), .RES_ADDR(RES_ADDR), .RD_LAT(RD_LAT)
    ) dut (
        .clk(clk), .reset(reset), .key_valid(key_valid), .key_digit(key_digit),
        .op_valid(op_valid), .op_code(op_code), .equal_input(equal_input),
        .clear_input(clear_input), .complete(complete), .overflow(overflow),
        .error(error), .display_output(display_output), .oe(oe), .we(we),
        .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory with RD_LAT-cycle read pipeline
    logic [15:0] mem [0:255];
    logic [15:0] pipe [0:RD_LAT-1];
    always @(posedge clk) begin
        if (we) mem[mem_addr[7:0]] <= mem_data_in;
        pipe[0] <= oe ? mem[mem_addr[7:0]] : 16'hDEAD;
        for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign mem_data_out = pipe[RD_LAT-1];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    typedef struct { logic [15:0] addr; logic [15:0] data; } wr_t;
    typedef struct { logic [15:0] res; logic ovf; logic err; int at; } done_t;
    wr_t         wr_q[$];
    logic [15:0] rd_q[$];
    done_t       done_q[$];

    // Monitor: pops expectations whenever the DUT presents bus activity or complete
    always @(negedge clk) begin
        if (reset) begin
            chk("oe_we_exclusive", {31'b0, oe & we}, 32'd0);
            if (we) begin
                if (wr_q.size() == 0) chk("unexpected_we", {16'b0, mem_addr}, 32'hFFFF_FFFF);
                else begin
                    wr_t w;
                    w = wr_q.pop_front();
                    chk("we_addr", {16'b0, mem_addr}, {16'b0, w.addr});
                    chk("we_data", {16'b0, mem_data_in}, {16'b0, w.data});
                end
            end
            if (oe) begin
                if (rd_q.size() == 0) chk("unexpected_oe", {16'b0, mem_addr}, 32'hFFFF_FFFF);
                else chk("oe_addr", {16'b0, mem_addr}, {16'b0, rd_q.pop_front()});
            end
            if (!oe && !we) chk("idle_bus", {mem_addr, mem_data_in}, 32'd0);
            if (complete) begin
                if (done_q.size() == 0) chk("unexpected_complete", 32'd1, 32'd0);
                else begin
                    done_t d;
                    d = done_q.pop_front();
                    chk("done_display", {16'b0, display_output}, {16'b0, d.res});
                    chk("done_overflow", {31'b0, overflow}, {31'b0, d.ovf});
                    chk("done_error", {31'b0, error}, {31'b0, d.err});
                    chk("done_latency", cyc, d.at);
                end
            end
        end
    end

    // Reference calculator: modes 0=entering A, 1=entering B, 2=result shown
    int          m_mode;
    longint      m_entry;
    logic [15:0] m_a, m_res, m_disp;
    int          m_op;
    bit          m_bdig, m_ovf, m_err;

    function automatic longint sx(input logic [15:0] v);
        return longint'($signed(v));
    endfunction

    task automatic model_reset();
        m_mode = 0; m_entry = 0; m_a = 0; m_res = 0; m_disp = 0;
        m_op = 0; m_bdig = 0; m_ovf = 0; m_err = 0;
    endtask

    task automatic model_calc(output logic [15:0] low, output bit ovf);
        longint full;
        logic [63:0] bits;
        longint b = sx(m_entry[15:0]);
        case (m_op)
            0: full = sx(m_a) + b;
            1: full = sx(m_a) - b;
            default: full = sx(m_a) * b;
        endcase
        bits = full;
        low  = bits[15:0];
        ovf  = (full < -32768) || (full > 32767);
    endtask

    task automatic model_clear();
        m_mode = 0; m_entry = 0; m_disp = 0; m_ovf = 0; m_err = 0; m_bdig = 0;
    endtask

    task automatic model_digit(input int d);
        if (d > 9) return;
        if (m_mode == 2) begin
            m_entry = d; m_disp = 16'(d); m_ovf = 0; m_mode = 0;
        end else begin
            if (m_mode == 1) m_bdig = 1;
            if (m_entry * 10 + d <= 32767) begin
                m_entry = m_entry * 10 + d; m_disp = m_entry[15:0]; m_ovf = 0;
            end
        end
    endtask

    task automatic model_op(input int c);
        if (c == 3) begin m_err = 1; return; end
        if (m_mode == 1) begin
            if (!m_bdig) m_op = c;
            return;
        end
        m_op = c;
        m_a = (m_mode == 0) ? m_entry[15:0] : m_res;
        wr_q.push_back('{A_ADDR, m_a});
        m_mode = 1; m_entry = 0; m_bdig = 0;
    endtask

    // Drive one strobe cycle; caller sits 1 time unit after a rising edge
    task automatic pulse(input bit kv, input logic [3:0] kd, input bit ov,
                         input logic [1:0] oc, input bit eq, input bit cl);
        key_valid = kv; key_digit = kd; op_valid = ov; op_code = oc;
        equal_input = eq; clear_input = cl;
        @(posedge clk); #1;
        key_valid = 0; key_digit = 0; op_valid = 0; op_code = 0;
        equal_input = 0; clear_input = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic check_status(input string tag);
        chk({tag, "_display"}, {16'b0, display_output}, {16'b0, m_disp});
        chk({tag, "_overflow"}, {31'b0, overflow}, {31'b0, m_ovf});
        chk({tag, "_error"}, {31'b0, error}, {31'b0, m_err});
    endtask

    task automatic do_digit(input int d);
        model_digit(d);
        pulse(1, 4'(d), 0, 0, 0, 0);
        idle(1);
        check_status("digit");
    endtask

    task automatic do_op(input int c);
        model_op(c);
        pulse(0, 0, 1, 2'(c), 0, 0);
        idle(2);
        check_status("op");
    endtask

    task automatic do_eq();
        if (m_mode == 1) begin
            logic [15:0] low;
            bit ovf;
            model_calc(low, ovf);
            rd_q.push_back(A_ADDR);
            wr_q.push_back('{RES_ADDR, low});
            done_q.push_back('{low, ovf, m_err, cyc + 4 + RD_LAT});
            m_res = low; m_disp = low; m_ovf = ovf; m_mode = 2;
            pulse(0, 0, 0, 0, 1, 0);
            idle(RD_LAT + 5);
        end else begin
            pulse(0, 0, 0, 0, 1, 0);
            idle(1);
        end
        check_status("equal");
    endtask

    task automatic do_clear();
        model_clear();
        pulse(0, 0, 0, 0, 0, 1);
        idle(1);
        check_status("clear");
    endtask

    initial begin
        reset = 0;
        key_valid = 0; key_digit = 0; op_valid = 0; op_code = 0;
        equal_input = 0; clear_input = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs",
            {26'b0, complete, overflow, error, oe, we, 1'b0},
            32'd0);
        chk("reset_display", {16'b0, display_output}, 32'd0);
        chk("reset_bus", {mem_addr, mem_data_in}, 32'd0);
        reset = 1;
        idle(1);

        // 123 + 45
        do_digit(1); do_digit(2); do_digit(3);
        do_op(0);
        do_digit(4); do_digit(5);
        do_eq();
        chk("sum_168", {16'b0, display_output}, 32'd168);

        // Entry saturation then signed overflow
        do_clear();
        do_digit(3); do_digit(2); do_digit(7); do_digit(6); do_digit(7); do_digit(8);
        chk("entry_max", {16'b0, display_output}, 32'd32767);
        do_op(0); do_digit(1); do_eq();
        chk("ovf_result", {15'b0, overflow, display_output}, {15'b0, 1'b1, 16'h8000});

        // Subtract then chained multiply
        do_clear();
        do_digit(5); do_op(1); do_digit(9); do_eq();
        chk("sub_neg4", {16'b0, display_output}, 32'h0000_FFFC);
        do_op(2); do_digit(3); do_eq();
        chk("chain_mul", {16'b0, display_output}, 32'h0000_FFF4);

        // Reserved op, then op with simultaneous digit: only op taken
        do_clear();
        do_digit(7);
        do_op(3);
        chk("reserved_err", {31'b0, error}, 32'd1);
        model_op(1);
        pulse(1, 4'd2, 1, 2'd1, 0, 0);
        idle(2);
        check_status("op_digit");
        do_digit(5);
        do_eq();
        chk("op_only_taken", {16'b0, display_output}, 32'd2);

        // Clear during the fetch wait aborts the calculation
        do_clear();
        do_digit(9); do_op(0); do_digit(1);
        rd_q.push_back(A_ADDR);
        pulse(0, 0, 0, 0, 1, 0);
        idle(1);
        model_clear();
        pulse(0, 0, 0, 0, 0, 1);
        idle(RD_LAT + 6);
        check_status("abort");
        chk("abort_no_done", done_q.size(), 32'd0);
        do_digit(4);

        // Asynchronous reset in the middle of the result write
        do_clear();
        do_digit(2); do_op(2); do_digit(6);
        rd_q.push_back(A_ADDR);
        pulse(0, 0, 0, 0, 1, 0);
        begin
            bit seen = 0;
            for (int i = 0; i < 20 && !seen; i++) begin
                if (we) seen = 1;
                else begin @(posedge clk); #1; end
            end
            chk("write_res_seen", {31'b0, seen}, 32'd1);
        end
        #1 reset = 0;
        #1;
        chk("async_reset_we_cpl", {30'b0, we, complete}, 32'd0);
        chk("async_reset_display", {16'b0, display_output}, 32'd0);
        @(posedge clk); #1;
        reset = 1;
        model_reset();
        idle(1);

        // Randomized event stream against the model
        for (int n = 0; n < 400; n++) begin
            int r = $urandom_range(0, 99);
            if (r < 55) do_digit($urandom_range(0, 9));
            else if (r < 60) do_digit($urandom_range(10, 15));
            else if (r < 75) do_op($urandom_range(0, 3));
            else if (r < 95) do_eq();
            else do_clear();
        end

        idle(RD_LAT + 6);
        chk("wr_q_drained", wr_q.size(), 32'd0);
        chk("rd_q_drained", rd_q.size(), 32'd0);
        chk("done_q_drained", done_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
